// File: rtl/inimigo_formacao_ctrl.sv
// rtl/inimigo_formacao_ctrl.sv - enemy formation step scheduler
//
// Owns the shared formation origin (form_x, form_y) and the horizontal
// direction for a COLS x ROWS enemy grid. Every step period it scans the
// vivo mask one column per cycle, then makes a one-cycle decision: step,
// descend, wave cleared or invaded.
//
// Optional feature macro: INIMIGO_SPEEDUP_EN
//   defined   : step period = TICK_MIN + alive_count*TICK_PER_ENEMY
//   undefined : step period = TICK_MAX
//
// Ports:
//   CLOCK_50       in   system clock
//   resetInimigo   in   asynchronous active-high reset
//   pausa          in   freeze the step timer (sampled only while waiting)
//   vivo_mask      in   bit r*COLS+c = enemy at row r, column c alive
//   form_x/form_y  out  formation origin (10 bit)
//   sentidoX       out  1 = moving right, 0 = moving left
//   step_pulse     out  one-cycle pulse on a horizontal step
//   descend_pulse  out  one-cycle pulse on a descend
//   alive_count    out  live enemies, latched at the end of each scan
//   wave_cleared   out  sticky, no enemies left
//   invaded        out  sticky, formation reached LIMIT_Y
//   busy           out  high while scanning or deciding
module inimigo_formacao_ctrl #(
    parameter int COLS           = 8,
    parameter int ROWS           = 4,
    parameter int SPACING_X      = 48,
    parameter int SPACING_Y      = 32,
    parameter int ENEMY_W        = 33,
    parameter int ENEMY_H        = 24,
    parameter int STEP_X         = 20,
    parameter int STEP_Y         = 20,
    parameter int SCREEN_W       = 640,
    parameter int LIMIT_Y        = 400,
    parameter int X0             = 40,
    parameter int Y0             = 40,
    parameter int TICK_MIN       = 2500000,
    parameter int TICK_PER_ENEMY = 703125,
    parameter int TICK_MAX       = 25000000
) (
    input  logic                 CLOCK_50,
    input  logic                 resetInimigo,
    input  logic                 pausa,
    input  logic [COLS*ROWS-1:0] vivo_mask,
    output logic [9:0]           form_x,
    output logic [9:0]           form_y,
    output logic                 sentidoX,
    output logic                 step_pulse,
    output logic                 descend_pulse,
    output logic [5:0]           alive_count,
    output logic                 wave_cleared,
    output logic                 invaded,
    output logic                 busy
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    // Edge arithmetic is carried in 11 bits so origin + offset never wraps.
    localparam logic [10:0] SPX_C  = 11'(SPACING_X);
    localparam logic [10:0] SPY_C  = 11'(SPACING_Y);
    localparam logic [10:0] EW_C   = 11'(ENEMY_W);
    localparam logic [10:0] EH_C   = 11'(ENEMY_H);
    localparam logic [10:0] STX_C  = 11'(STEP_X);
    localparam logic [10:0] SCRW_C = 11'(SCREEN_W);
    localparam logic [10:0] LIMY_C = 11'(LIMIT_Y);

    typedef enum logic [2:0] {
        S_WAIT,
        S_SCAN,
        S_DECIDE,
        S_CLEARED,
        S_INVADED
    } state_t;

    state_t          state_q, state_d;
    logic [24:0]     tick_q, tick_d;
    logic [CW-1:0]   col_q, col_d;
    logic [CW-1:0]   min_col_q, min_col_d;
    logic [CW-1:0]   max_col_q, max_col_d;
    logic            seen_q, seen_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [ROWS-1:0] row_acc_q, row_acc_d;
    logic [9:0]      form_x_q, form_x_d;
    logic [9:0]      form_y_q, form_y_d;
    logic            sentido_q, sentido_d;
    logic [5:0]      alive_q, alive_d;
    logic            cleared_q, cleared_d;
    logic            invaded_q, invaded_d;

    logic [24:0]     period;
    logic [24:0]     period_m1;
    logic [ROWS-1:0] col_bits;
    logic [5:0]      col_pop;
    logic [RW-1:0]   max_row;
    logic [10:0]     left_x;
    logic [10:0]     right_x;
    logic [10:0]     bottom_y;
    logic [9:0]      desc_y;
    logic [9:0]      new_y;
    logic            hit_edge;
    logic            hit_limit;

`ifdef INIMIGO_SPEEDUP_EN
    assign period = 25'(TICK_MIN) + 25'(alive_q) * 25'(TICK_PER_ENEMY);
    logic [24:0] unused_tick_max;
    assign unused_tick_max = 25'(TICK_MAX);
`else
    assign period = 25'(TICK_MAX);
    logic [49:0] unused_tick_speedup;
    assign unused_tick_speedup = {25'(TICK_MIN), 25'(TICK_PER_ENEMY)};
`endif
    assign period_m1 = period - 25'd1;

    // Column c of the mask: one bit per row.
    always_comb begin
        col_bits = '0;
        for (int r = 0; r < ROWS; r++) begin
            col_bits[r] = vivo_mask[r*COLS + int'(col_q)];
        end
    end

    always_comb begin
        col_pop = '0;
        for (int r = 0; r < ROWS; r++) begin
            col_pop = col_pop + 6'(col_bits[r]);
        end
    end

    // Lowest row that still holds a live enemy (highest row index).
    always_comb begin
        max_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_acc_q[r]) begin
                max_row = RW'(r);
            end
        end
    end

    assign left_x   = {1'b0, form_x_q} + 11'(min_col_q) * SPX_C;
    assign right_x  = {1'b0, form_x_q} + 11'(max_col_q) * SPX_C + EW_C;
    assign hit_edge = sentido_q ? (right_x + STX_C > SCRW_C) : (left_x < STX_C);
    assign desc_y   = form_y_q + 10'(STEP_Y);
    // Invasion is judged on the origin after this decision's descend.
    assign new_y     = hit_edge ? desc_y : form_y_q;
    assign bottom_y  = {1'b0, new_y} + 11'(max_row) * SPY_C + EH_C;
    assign hit_limit = (bottom_y >= LIMY_C);

    always_comb begin
        state_d       = state_q;
        tick_d        = tick_q;
        col_d         = col_q;
        min_col_d     = min_col_q;
        max_col_d     = max_col_q;
        seen_d        = seen_q;
        cnt_d         = cnt_q;
        row_acc_d     = row_acc_q;
        form_x_d      = form_x_q;
        form_y_d      = form_y_q;
        sentido_d     = sentido_q;
        alive_d       = alive_q;
        cleared_d     = cleared_q;
        invaded_d     = invaded_q;
        step_pulse    = 1'b0;
        descend_pulse = 1'b0;

        case (state_q)
            S_WAIT: begin
                if (!pausa) begin
                    // >= guards against the period shrinking below the count.
                    if (tick_q >= period_m1) begin
                        tick_d    = '0;
                        state_d   = S_SCAN;
                        col_d     = '0;
                        min_col_d = '0;
                        max_col_d = '0;
                        seen_d    = 1'b0;
                        cnt_d     = '0;
                        row_acc_d = '0;
                    end else begin
                        tick_d = tick_q + 25'd1;
                    end
                end
            end

            S_SCAN: begin
                if (col_bits != '0) begin
                    if (!seen_q) begin
                        min_col_d = col_q;
                    end
                    max_col_d = col_q;
                    seen_d    = 1'b1;
                end
                cnt_d     = cnt_q + col_pop;
                row_acc_d = row_acc_q | col_bits;
                if (col_q == CW'(COLS - 1)) begin
                    state_d = S_DECIDE;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end

            S_DECIDE: begin
                alive_d = cnt_q;
                if (cnt_q == '0) begin
                    cleared_d = 1'b1;
                    state_d   = S_CLEARED;
                end else begin
                    if (hit_edge) begin
                        form_y_d      = desc_y;
                        sentido_d     = ~sentido_q;
                        descend_pulse = 1'b1;
                    end else begin
                        step_pulse = 1'b1;
                        form_x_d   = sentido_q ? form_x_q + 10'(STEP_X)
                                               : form_x_q - 10'(STEP_X);
                    end
                    if (hit_limit) begin
                        invaded_d = 1'b1;
                        state_d   = S_INVADED;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_CLEARED, S_INVADED: begin
            end

            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
        if (resetInimigo) begin
            state_q   <= S_WAIT;
            tick_q    <= '0;
            col_q     <= '0;
            min_col_q <= '0;
            max_col_q <= '0;
            seen_q    <= 1'b0;
            cnt_q     <= '0;
            row_acc_q <= '0;
            form_x_q  <= 10'(X0);
            form_y_q  <= 10'(Y0);
            sentido_q <= 1'b0;
            alive_q   <= 6'(COLS * ROWS);
            cleared_q <= 1'b0;
            invaded_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            col_q     <= col_d;
            min_col_q <= min_col_d;
            max_col_q <= max_col_d;
            seen_q    <= seen_d;
            cnt_q     <= cnt_d;
            row_acc_q <= row_acc_d;
            form_x_q  <= form_x_d;
            form_y_q  <= form_y_d;
            sentido_q <= sentido_d;
            alive_q   <= alive_d;
            cleared_q <= cleared_d;
            invaded_q <= invaded_d;
        end
    end

    assign form_x       = form_x_q;
    assign form_y       = form_y_q;
    assign sentidoX     = sentido_q;
    assign alive_count  = alive_q;
    assign wave_cleared = cleared_q;
    assign invaded      = invaded_q;
    assign busy         = (state_q == S_SCAN) || (state_q == S_DECIDE);

endmodule

// File: tb/tb_inimigo_formacao_ctrl.sv
// tb/tb_inimigo_formacao_ctrl.sv - directed self-checking bench for inimigo_formacao_ctrl
module tb_inimigo_formacao_ctrl;

    localparam int COLS  = 8;
    localparam int ROWS  = 4;
    localparam int TICKP = 100;
    localparam int LAT   = TICKP + COLS;   // posedges from WAIT entry to the DECIDE cycle

    logic        CLOCK_50 = 1'b0;
    logic        resetInimigo;
    logic        pausa;
    logic [31:0] vivo_mask;
    logic [9:0]  form_x;
    logic [9:0]  form_y;
    logic        sentidoX;
    logic        step_pulse;
    logic        descend_pulse;
    logic [5:0]  alive_count;
    logic        wave_cleared;
    logic        invaded;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int   m_fx, m_fy, m_sx, m_alive;
    logic m_step, m_desc, m_inv, m_clr;

    inimigo_formacao_ctrl #(
        .TICK_MIN      (10),
        .TICK_PER_ENEMY(2),
        .TICK_MAX      (TICKP)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .resetInimigo (resetInimigo),
        .pausa        (pausa),
        .vivo_mask    (vivo_mask),
        .form_x       (form_x),
        .form_y       (form_y),
        .sentidoX     (sentidoX),
        .step_pulse   (step_pulse),
        .descend_pulse(descend_pulse),
        .alive_count  (alive_count),
        .wave_cleared (wave_cleared),
        .invaded      (invaded),
        .busy         (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Behavioural model of one decision on mask m.
    task automatic model(input logic [31:0] m);
        int cnt, mn, mx, mr, left, right;
        cnt = 0; mn = -1; mx = 0; mr = 0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (m[r*COLS + c]) begin
                    cnt++;
                    if (mn < 0) mn = c;
                    mx = c;
                    if (r > mr) mr = r;
                end
            end
        end
        m_alive = cnt;
        m_step = 1'b0; m_desc = 1'b0; m_inv = 1'b0; m_clr = 1'b0;
        if (cnt == 0) begin
            m_clr = 1'b1;
        end else begin
            left  = m_fx + mn * 48;
            right = m_fx + mx * 48 + 33;
            if ((m_sx == 1 && right + 20 > 640) || (m_sx == 0 && left < 20)) begin
                m_fy   = m_fy + 20;
                m_sx   = 1 - m_sx;
                m_desc = 1'b1;
            end else begin
                m_step = 1'b1;
                m_fx   = (m_sx == 1) ? m_fx + 20 : m_fx - 20;
            end
            if (m_fy + mr * 32 + 24 >= 400) m_inv = 1'b1;
        end
    endtask

    // Wait (bounded) for a pulse; cyc counts posedges since the call.
    task automatic wait_pulse(output int cyc, output logic st, output logic ds);
        cyc = 0; st = 1'b0; ds = 1'b0;
        while (cyc < 400) begin
            @(posedge CLOCK_50);
            cyc++;
            @(negedge CLOCK_50);
            if (step_pulse || descend_pulse) begin
                st = step_pulse;
                ds = descend_pulse;
                break;
            end
        end
    endtask

    task automatic decide_step(input string tag);
        int   cyc;
        logic st, ds;
        model(vivo_mask);
        wait_pulse(cyc, st, ds);
        chk({tag, ".latency"}, cyc, LAT);
        chk({tag, ".step_pulse"}, st, m_step);
        chk({tag, ".descend_pulse"}, ds, m_desc);
        chk({tag, ".busy_decide"}, busy, 1);
        @(posedge CLOCK_50);
        #1;
        chk({tag, ".form_x"}, form_x, m_fx);
        chk({tag, ".form_y"}, form_y, m_fy);
        chk({tag, ".sentidoX"}, sentidoX, m_sx);
        chk({tag, ".alive_count"}, alive_count, m_alive);
        chk({tag, ".invaded"}, invaded, m_inv);
        chk({tag, ".pulses_cleared"}, {step_pulse, descend_pulse}, 0);
    endtask

    initial begin
        int viol, n, cyc;
        logic seen;

        resetInimigo = 1'b1;
        pausa        = 1'b0;
        vivo_mask    = '1;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("reset.form_x", form_x, 40);
        chk("reset.form_y", form_y, 40);
        chk("reset.sentidoX", sentidoX, 0);
        chk("reset.step_pulse", step_pulse, 0);
        chk("reset.descend_pulse", descend_pulse, 0);
        chk("reset.alive_count", alive_count, 32);
        chk("reset.wave_cleared", wave_cleared, 0);
        chk("reset.invaded", invaded, 0);
        chk("reset.busy", busy, 0);

        resetInimigo = 1'b0;
        m_fx = 40; m_fy = 40; m_sx = 0;

        // First step: 40 -> 20, then 20 -> 0, then left edge descend.
        decide_step("first_step");
        chk("first_step.form_x_lit", form_x, 20);
        decide_step("left_step");
        chk("left_step.form_x_lit", form_x, 0);
        decide_step("left_descend");
        chk("left_descend.form_y_lit", form_y, 60);
        chk("left_descend.sentidoX_lit", sentidoX, 1);
        chk("left_descend.form_x_lit", form_x, 0);

        // Walk right 0 -> 260.
        for (int k = 0; k < 13; k++) decide_step("right_walk");
        chk("right_walk.form_x_lit", form_x, 260);

        // Only column 7 alive: right = 260+336+33 = 629, 649 > 640 -> descend.
        vivo_mask = 32'h8080_8080;
        decide_step("col7_descend");
        chk("col7_descend.form_y_lit", form_y, 80);
        chk("col7_descend.alive_lit", alive_count, 4);
        chk("col7_descend.sentidoX_lit", sentidoX, 0);

        // Pause 500 cycles: nothing moves, the timer holds.
        pausa = 1'b1;
        viol = 0;
        repeat (500) begin
            @(negedge CLOCK_50);
            if (step_pulse || descend_pulse || busy || form_x != 10'd260) viol++;
        end
        chk("pause.activity", viol, 0);
        pausa = 1'b0;
        decide_step("after_pause");
        chk("after_pause.form_x_lit", form_x, 240);

        // Full grid zigzag down to the invasion line (280+96+24 = 400).
        vivo_mask = '1;
        n = 0;
        while (!m_inv && n < 200) begin
            decide_step("zigzag");
            n++;
        end
        chk("invade.flag", invaded, 1);
        chk("invade.form_y_lit", form_y, 280);
        viol = 0;
        repeat (300) begin
            @(negedge CLOCK_50);
            if (step_pulse || descend_pulse || busy || form_x != 10'(m_fx) || form_y != 10'(m_fy)) viol++;
        end
        chk("invade.frozen", viol, 0);

        // Reset mid-scan after one step.
        resetInimigo = 1'b1;
        @(negedge CLOCK_50);
        resetInimigo = 1'b0;
        m_fx = 40; m_fy = 40; m_sx = 0;
        decide_step("post_reset");
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge CLOCK_50);
            if (busy) seen = 1'b1;
        end
        chk("midscan.busy_seen", seen, 1);
        @(posedge CLOCK_50);
        #2;
        resetInimigo = 1'b1;
        #1;
        chk("midscan.form_x", form_x, 40);
        chk("midscan.busy", busy, 0);
        chk("midscan.invaded", invaded, 0);

        // Empty mask: one scan then wave cleared, no pulses.
        vivo_mask = '0;
        @(negedge CLOCK_50);
        resetInimigo = 1'b0;
        cyc = 0; viol = 0;
        while (cyc < 400 && !wave_cleared) begin
            @(posedge CLOCK_50);
            cyc++;
            @(negedge CLOCK_50);
            if (step_pulse || descend_pulse) viol++;
        end
        chk("clear.latency", cyc, LAT + 1);
        chk("clear.no_pulse", viol, 0);
        chk("clear.flag", wave_cleared, 1);
        chk("clear.alive_count", alive_count, 0);
        viol = 0;
        repeat (300) begin
            @(negedge CLOCK_50);
            if (step_pulse || descend_pulse || busy || form_x != 10'd40 || form_y != 10'd40) viol++;
        end
        chk("clear.frozen", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
